alsu_pipe: RTL and testbench

Parametrised, pipelined arithmetic/logic/shift unit: the next-generation ALSU with configurable operand width, valid/ready flow control and a double-width result.
- Two register stages (operand capture, then execute).
- Signed add and multiply, bitwise or reduction OR/XOR, and 1-bit shift/rotate of the previous result.
- Invalid-operation flag plus an LED blink indicator.
- Sits between the stimulus/control front-end and the result consumer in the ALSU subsystem.

---
 rtl/alsu_pkg.sv | 20 ++
 rtl/alsu_pipe_if.sv | 37 +++
 rtl/alsu_blink.sv | 34 +++
 rtl/alsu_pipe.sv | 127 ++++++++++++
 tb/tb_alsu_pipe.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alsu_pkg.sv
// Shared opcode encoding and operation-validity check for the pipelined ALSU.
package alsu_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_OR     = 3'd0,
    OP_XOR    = 3'd1,
    OP_ADD    = 3'd2,
    OP_MUL    = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_ROTATE = 3'd5
  } opcode_e;

  // Reduction selects only make sense for the bitwise OR/XOR operations.
  function automatic logic is_invalid(input logic [OPCODE_W-1:0] op, input logic red);
    return (op > OP_ROTATE) || (red && (op != OP_OR) && (op != OP_XOR));
  endfunction

endpackage

// File: rtl/alsu_pipe_if.sv
// Operation/result bus of the pipelined ALSU: valid/ready in, valid/ready out.
interface alsu_pipe_if
  import alsu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LED_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      A;
  logic [WIDTH-1:0]      B;
  logic                  cin;
  logic [OPCODE_W-1:0]   opcode;
  logic                  red_op_A;
  logic                  red_op_B;
  logic                  bypass_A;
  logic                  bypass_B;
  logic                  direction;
  logic                  serial_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*WIDTH-1:0]    out;
  logic                  err;
  logic [LED_W-1:0]      leds;

  modport master (
    output in_valid, A, B, cin, opcode, red_op_A, red_op_B,
           bypass_A, bypass_B, direction, serial_in, out_ready,
    input  in_ready, out_valid, out, err, leds
  );

  modport slave (
    input  in_valid, A, B, cin, opcode, red_op_A, red_op_B,
           bypass_A, bypass_B, direction, serial_in, out_ready,
    output in_ready, out_valid, out, err, leds
  );
endinterface

// File: rtl/alsu_blink.sv
// LED blinker: toggles all LEDs every BLINK_DIV cycles while the held result is an error.
module alsu_blink #(
  parameter int LED_W     = 16,
  parameter int BLINK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             err_next,
  input  logic             err_cur,
  output logic [LED_W-1:0] leds
);
  localparam int CNT_W = $clog2(BLINK_DIV + 1);

  logic [CNT_W-1:0] cnt;

  // A newly loaded result restarts the blink period; a clean result also darkens the LEDs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      leds <= '0;
    end else if (load) begin
      cnt <= '0;
      if (!err_next) leds <= '0;
    end else if (err_cur) begin
      if (cnt == CNT_W'(BLINK_DIV - 1)) begin
        cnt  <= '0;
        leds <= ~leds;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/alsu_pipe.sv
// Two-stage pipelined ALSU (operand capture, execute) with valid/ready flow control.
// Define ALSU_PIPE_BLINK_EN to blink the LEDs on error; otherwise they mirror err.
module alsu_pipe
  import alsu_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter     INPUT_PRIORITY = "A",
  parameter int FULL_ADDER     = 1,
  parameter int LED_W          = 16,
  parameter int BLINK_DIV      = 4
) (
  input logic        clk,
  input logic        rst,
  alsu_pipe_if.slave bus
);
  localparam int W2     = 2 * WIDTH;
  localparam bit PRIO_A = (INPUT_PRIORITY != "B");

  typedef struct packed {
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                cin;
    logic [OPCODE_W-1:0] opcode;
    logic                red_a;
    logic                red_b;
    logic                byp_a;
    logic                byp_b;
    logic                dir;
    logic                ser;
  } s1_t;

  s1_t              s1;
  logic             s1_valid;
  logic             out_valid_q;
  logic [W2-1:0]    out_q;
  logic             err_q;
  logic             s1_load, s2_load, exec;
  logic [W2-1:0]    res, cin_ext;
  logic             res_err;
  logic signed [W2-1:0] ax, bx;
  logic [WIDTH-1:0] red_x;
  logic             use_a, red_sel;

  assign s2_load      = !out_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign exec         = s2_load && s1_valid;
  assign bus.in_ready = s1_load;
  assign cin_ext      = (FULL_ADDER != 0) ? {{(W2-1){1'b0}}, s1.cin} : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s1_valid <= 1'b0;
    else if (s1_load) s1_valid <= bus.in_valid;
  end

  // NOTE: operand payload has no reset; s1_valid qualifies it, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (s1_load && bus.in_valid) begin
      s1 <= '{a: bus.A, b: bus.B, cin: bus.cin, opcode: bus.opcode,
              red_a: bus.red_op_A, red_b: bus.red_op_B,
              byp_a: bus.bypass_A, byp_b: bus.bypass_B,
              dir: bus.direction, ser: bus.serial_in};
    end
  end

  // out_q doubles as the shift/rotate accumulator, so it updates on every execute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_q <= res;
        err_q <= res_err;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    res     = '0;
    res_err = 1'b0;
    ax      = {{WIDTH{s1.a[WIDTH-1]}}, s1.a};
    bx      = {{WIDTH{s1.b[WIDTH-1]}}, s1.b};
    use_a   = (s1.byp_a && s1.byp_b) ? PRIO_A : s1.byp_a;
    red_sel = (s1.red_a && s1.red_b) ? PRIO_A : s1.red_a;
    red_x   = red_sel ? s1.a : s1.b;
    if (s1.byp_a || s1.byp_b) begin
      res = use_a ? ax : bx;
    end else if (is_invalid(s1.opcode, s1.red_a || s1.red_b)) begin
      res_err = 1'b1;
    end else begin
      case (s1.opcode)
        OP_OR:     res = (s1.red_a || s1.red_b) ? {{(W2-1){1'b0}}, |red_x} : (ax | bx);
        OP_XOR:    res = (s1.red_a || s1.red_b) ? {{(W2-1){1'b0}}, ^red_x} : (ax ^ bx);
        OP_ADD:    res = ax + bx + cin_ext;
        OP_MUL:    res = ax * bx;
        OP_SHIFT:  res = s1.dir ? {out_q[W2-2:0], s1.ser} : {s1.ser, out_q[W2-1:1]};
        OP_ROTATE: res = s1.dir ? {out_q[W2-2:0], out_q[W2-1]} : {out_q[0], out_q[W2-1:1]};
        default:   res = '0;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.err       = err_q;

`ifdef ALSU_PIPE_BLINK_EN
  alsu_blink #(
    .LED_W    (LED_W),
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk     (clk),
    .rst     (rst),
    .load    (exec),
    .err_next(res_err),
    .err_cur (err_q),
    .leds    (bus.leds)
  );
`else
  assign bus.leds = {LED_W{err_q}};
`endif

endmodule

// File: tb/tb_alsu_pipe.sv
// Scoreboard bench for alsu_pipe (WIDTH=8): expected results queued at drive, compared at output.
module tb_alsu_pipe;
  import alsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alsu_pipe_if #(.WIDTH(8), .LED_W(16)) bus ();

  alsu_pipe #(
    .WIDTH(8), .INPUT_PRIORITY("A"), .FULL_ADDER(1), .LED_W(16), .BLINK_DIV(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [2:0] opcode;
    logic       red_a;
    logic       red_b;
    logic       byp_a;
    logic       byp_b;
    logic       dir;
    logic       ser;
  } op_t;

  typedef struct packed {
    logic [15:0] out;
    logic        err;
  } res_t;

  res_t        sb_q[$];
  logic [15:0] model_acc;
  int          n_tests  = 0;
  int          n_fail   = 0;
  int          n_accept = 0;

`ifdef ALSU_PIPE_BLINK_EN
  localparam logic [15:0] LED_ERR_IDLE = 16'h0000;
`else
  localparam logic [15:0] LED_ERR_IDLE = 16'hFFFF;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model written in plain integer arithmetic.
  function automatic res_t model(input op_t o, input logic [15:0] acc);
    res_t r;
    int ia, ib, v;
    logic [7:0] x;
    ia = $signed(o.a);
    ib = $signed(o.b);
    r.err = 1'b0;
    r.out = 16'h0000;
    x = o.red_a ? o.a : o.b;
    if (o.byp_a) begin
      v = ia; r.out = v[15:0];
    end else if (o.byp_b) begin
      v = ib; r.out = v[15:0];
    end else if (o.opcode >= 3'd6 || ((o.red_a || o.red_b) && o.opcode >= 3'd2)) begin
      r.err = 1'b1;
    end else begin
      case (o.opcode)
        3'd0: begin v = ia | ib; r.out = (o.red_a || o.red_b) ? {15'd0, |x} : v[15:0]; end
        3'd1: begin v = ia ^ ib; r.out = (o.red_a || o.red_b) ? {15'd0, ^x} : v[15:0]; end
        3'd2: begin v = ia + ib + int'(o.cin); r.out = v[15:0]; end
        3'd3: begin v = ia * ib; r.out = v[15:0]; end
        3'd4: r.out = o.dir ? {acc[14:0], o.ser} : {o.ser, acc[15:1]};
        default: r.out = o.dir ? {acc[14:0], acc[15]} : {acc[0], acc[15:1]};
      endcase
    end
    return r;
  endfunction

  function automatic op_t mk(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b);
    op_t o;
    o = '0;
    o.opcode = opc;
    o.a = a;
    o.b = b;
    return o;
  endfunction

  // Called at #1 after a rising edge; returns #1 after the accepting edge with in_valid still high.
  task automatic send(input op_t o);
    res_t e;
    logic rdy;
    e = model(o, model_acc);
    sb_q.push_back(e);
    model_acc      = e.out;
    bus.A          = o.a;
    bus.B          = o.b;
    bus.cin        = o.cin;
    bus.opcode     = o.opcode;
    bus.red_op_A   = o.red_a;
    bus.red_op_B   = o.red_b;
    bus.bypass_A   = o.byp_a;
    bus.bypass_B   = o.byp_b;
    bus.direction  = o.dir;
    bus.serial_in  = o.ser;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        n_accept++;
        return;
      end
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) return;
    end
    check("drain_timeout", sb_q.size(), 0);
  endtask

  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_extra", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_out", bus.out, e.out);
          check("sb_err", bus.err, e.err);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    op_t o;
    int  ghosts;
    model_acc     = 16'h0000;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = '0; bus.B = '0; bus.cin = 1'b0; bus.opcode = '0;
    bus.red_op_A = 1'b0; bus.red_op_B = 1'b0; bus.bypass_A = 1'b0; bus.bypass_B = 1'b0;
    bus.direction = 1'b0; bus.serial_in = 1'b0;

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_err", bus.err, 0);
    check("rst_leds", bus.leds, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // ADD -3 + 5 + cin, with latency check
    o = mk(3'd2, 8'hFD, 8'h05); o.cin = 1'b1;
    send(o);
    idle();
    @(negedge clk); check("lat_n1", bus.out_valid, 0);
    @(negedge clk); check("lat_n2", bus.out_valid, 1);
    drain();

    // MUL then chained rotates and a right shift
    send(mk(3'd3, 8'h80, 8'h80));
    o = mk(3'd5, 8'h00, 8'h00); o.dir = 1'b1;
    send(o);
    send(o);
    o = mk(3'd4, 8'h00, 8'h00); o.dir = 1'b0; o.ser = 1'b1;
    send(o);
    idle();
    drain();

    // Invalid opcode and LED behaviour
    send(mk(3'd6, 8'h12, 8'h34));
    idle();
    @(posedge clk);
    @(negedge clk); check("blink0", bus.leds, LED_ERR_IDLE);
    repeat (3) @(posedge clk);
    @(negedge clk); check("blink3", bus.leds, LED_ERR_IDLE);
    @(posedge clk);
    @(negedge clk); check("blink4", bus.leds, 16'hFFFF);
    @(posedge clk);
    #1;
    send(mk(3'd2, 8'h01, 8'h02));
    idle();
    @(negedge clk); check("blink_hold", bus.leds, 16'hFFFF);
    @(posedge clk);
    @(negedge clk); check("blink_clr", bus.leds, 16'h0000);
    drain();

    // Back-pressure: four ops offered while out_ready is low
    bus.out_ready = 1'b0;
    n_accept = 0;
    fork
      begin
        o = mk(3'd0, 8'h80, 8'h00); o.red_a = 1'b1;
        send(o);
        o = mk(3'd1, 8'h03, 8'hFF); o.red_a = 1'b1; o.red_b = 1'b1;
        send(o);
        send(mk(3'd0, 8'h81, 8'h02));
        o = mk(3'd4, 8'h00, 8'h00); o.dir = 1'b1;
        send(o);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("stall_rdy", bus.in_ready, 0);
        check("stall_acc", n_accept, 2);
        check("stall_hold", bus.out, sb_q[0].out);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reduction with arithmetic opcode, bypass override, bypass priority, opcode 7
    o = mk(3'd2, 8'h05, 8'hFF); o.red_a = 1'b1;
    send(o);
    o.byp_b = 1'b1;
    send(o);
    o = mk(3'd3, 8'h7F, 8'h80); o.byp_a = 1'b1; o.byp_b = 1'b1;
    send(o);
    send(mk(3'd7, 8'h01, 8'h01));
    idle();
    drain();

    // Reset with one result held and one op in flight
    bus.out_ready = 1'b0;
    send(mk(3'd3, 8'h03, 8'h05));
    send(mk(3'd2, 8'h01, 8'h01));
    idle();
    check("rst_pre_valid", bus.out_valid, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_out", bus.out, 0);
    check("rst_mid_err", bus.err, 0);
    check("rst_mid_leds", bus.leds, 0);
    sb_q.delete();
    model_acc = 16'h0000;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ghosts = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) ghosts++;
    end
    check("no_ghost", ghosts, 0);

    // Accumulator restarts from zero after reset
    @(posedge clk);
    #1;
    o = mk(3'd4, 8'h00, 8'h00); o.dir = 1'b1; o.ser = 1'b1;
    send(o);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
